// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// Purely combinational wiring; no latency. mem_ready is the only backpressure signal.
// Master is the controller side, slave is the datapath/memory side.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, mem_timeout
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, mem_timeout
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS: fetch/decode/execute/mem/write-back sequencing.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles; outputs registered except FETCH ir_write/pc_write.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their strobes until mem_ready; wait cycles counted.
module mips_multicycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    // Moore part of the control word; FETCH's ir_write/pc_write pulse is added on mem_ready.
    function automatic ctrl_t ctrl_for(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:    c.alu_src_b = 2'b11;
            MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEM_RD:    begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEM_WR:    begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH:    begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            end
            JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDI_WB:   c.reg_write = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_e     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_op_q, illegal_op_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic       mem_state;
    logic       stalled;
    logic       fetch_strobe;

    assign mem_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign stalled   = mem_state && !bus.mem_ready;

    always_comb begin
        state_d       = state_q;
        illegal_op_d  = illegal_op_q;
        case (state_q)
            FETCH:     if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = R_EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    default: begin
                        state_d      = FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:    if (bus.mem_ready) state_d = MEM_WB;
            MEM_WR:    if (bus.mem_ready) state_d = FETCH;
            R_EXEC:    state_d = R_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            default:   state_d = FETCH;
        endcase

        // Leaving a memory state needs mem_ready, so clearing on every non-stall cycle
        // is the same as clearing on entry.
        wait_cnt_d    = 4'd0;
        mem_timeout_d = mem_timeout_q;
        if (stalled) begin
            wait_cnt_d    = (wait_cnt_q >= WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 4'd1;
            mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_MAX);
        end

        ctrl_d = ctrl_for(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            ctrl_q        <= ctrl_for(FETCH);
            wait_cnt_q    <= 4'd0;
            illegal_op_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            wait_cnt_q    <= wait_cnt_d;
            illegal_op_q  <= illegal_op_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign fetch_strobe      = (state_q == FETCH) && bus.mem_ready && !reset;
    assign bus.pc_write      = ctrl_q.pc_write || fetch_strobe;
    assign bus.ir_write      = fetch_strobe;
    assign bus.pc_write_cond = ctrl_q.pc_write_cond;
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.state         = state_q;
    assign bus.illegal_op    = illegal_op_q;
    assign bus.mem_timeout   = mem_timeout_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction state paths and a per-state output table
// predict every cycle; directed cases first, then random opcodes and memory wait lengths.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    mips_multicycle_control_if bus ();

    mips_multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control word bit order:
    // pc_write pc_write_cond i_or_d mem_read | mem_write ir_write mem_to_reg reg_dst |
    // reg_write alu_src_a alu_src_b[1:0] | alu_op[1:0] pc_source[1:0]
    logic [15:0] tbl [12];
    logic        m_illegal = 1'b0;
    logic        m_timeout = 1'b0;

    function automatic logic is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    function automatic logic [21:0] observed();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.state, bus.illegal_op,
                bus.mem_timeout};
    endfunction

    // Called just after a falling edge; leaves just after the next falling edge.
    task automatic step(input string tag, input int st, input logic mr, input logic [5:0] op);
        logic [15:0] c;
        logic [21:0] exp;
        logic [21:0] got;
        bus.mem_ready = mr;
        bus.opcode    = op;
        #1;
        c = tbl[st];
        if (st == 0 && mr) c = c | 16'h8400;
        exp = {c, 4'(st), m_illegal, m_timeout};
        got = observed();
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s state=%0d observed=%h expected=%h", tag, st, got, exp);
        end
        @(negedge clk);
    endtask

    task automatic reset_check(input string tag);
        logic [21:0] exp;
        logic [21:0] got;
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
        exp = {tbl[0], 4'd0, 1'b0, 1'b0};
        got = observed();
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // fw/dw: mem_ready-low cycles in FETCH and in the data memory state.
    // rst_at >= 0 asserts reset instead of that step and abandons the instruction.
    task automatic run_instr(input string tag, input logic [5:0] op, input int fw,
                             input int dw, input int rst_at);
        int path[$];
        int k = 0;
        case (op)
            6'b000000: path = '{0, 1, 6, 7};
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 9};
            6'b001000: path = '{0, 1, 10, 11};
            default:   path = '{0, 1};
        endcase
        foreach (path[i]) begin
            int st = path[i];
            if (st == 0 || st == 3 || st == 5) begin
                int waits = (st == 0) ? fw : dw;
                int streak = 0;
                for (int w = 0; w <= waits; w++) begin
                    logic mr = (w < waits) ? 1'b0 : 1'b1;
                    if (k == rst_at) begin
                        reset_check({tag, "_reset"});
                        return;
                    end
                    step(tag, st, mr, op);
                    k++;
                    if (!mr) begin
                        streak++;
                        if (streak >= 15) m_timeout = 1'b1;
                    end
                end
            end else begin
                if (k == rst_at) begin
                    reset_check({tag, "_reset"});
                    return;
                end
                step(tag, st, 1'($urandom_range(0, 1)), op);
                k++;
                if (st == 1 && !is_legal(op)) m_illegal = 1'b1;
            end
        end
    endtask

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] op;
        int fw;
        int dw;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        tbl[0]  = 16'b0001_0000_0001_0000;
        tbl[1]  = 16'b0000_0000_0011_0000;
        tbl[2]  = 16'b0000_0000_0110_0000;
        tbl[3]  = 16'b0011_0000_0000_0000;
        tbl[4]  = 16'b0000_0010_1000_0000;
        tbl[5]  = 16'b0010_1000_0000_0000;
        tbl[6]  = 16'b0000_0000_0100_1000;
        tbl[7]  = 16'b0000_0001_1000_0000;
        tbl[8]  = 16'b0100_0000_0100_0101;
        tbl[9]  = 16'b1000_0000_0000_0010;
        tbl[10] = 16'b0000_0000_0110_0000;
        tbl[11] = 16'b0000_0000_1000_0000;
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b0;

        repeat (2) @(negedge clk);
        reset_check("reset");

        run_instr("lw",       6'b100011, 0, 0, -1);
        run_instr("rtype",    6'b000000, 0, 0, -1);
        run_instr("beq",      6'b000100, 0, 0, -1);
        run_instr("j",        6'b000010, 0, 0, -1);
        run_instr("addi",     6'b001000, 0, 0, -1);
        run_instr("sw_wait3", 6'b101011, 0, 3, -1);
        run_instr("lw_wait2", 6'b100011, 1, 2, -1);
        run_instr("fetch14",  6'b000000, 14, 0, -1);
        run_instr("fetch15",  6'b000000, 15, 0, -1);
        run_instr("after_to", 6'b000100, 0, 0, -1);
        run_instr("illegal",  6'b111111, 0, 0, -1);
        run_instr("rst_rexec", 6'b000000, 0, 0, 2);
        run_instr("post_rst", 6'b001000, 0, 0, -1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
            end
            fw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            dw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            if ($urandom_range(0, 14) == 0)
                run_instr("rand_rst", op, fw, dw, $urandom_range(0, 3));
            else
                run_instr("rand", op, fw, dw, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM for the multi-cycle MIPS datapath variant. It sequences each instruction through fetch, decode, execute, memory and write-back steps, and drives the datapath mux selects and write enables. It produces the 2-bit `alu_op` consumed directly by the ALU control stage. It also stalls on a memory-ready handshake.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum wait cycles on `mem_ready` before `mem_timeout` is asserted.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces FSM to FETCH and clears flags.
- `opcode` in 6: `instr[31:26]` from the instruction register.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `pc_write`, `pc_write_cond` out 1: unconditional PC write; PC write when the ALU zero flag is set (beq).
- `i_or_d` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_read`, `mem_write` out 1: memory strobes, held until `mem_ready`.
- `ir_write` out 1: instruction register load.
- `mem_to_reg`, `reg_dst`, `reg_write` out 1: register-file write controls.
- `alu_src_a` out 1: 0 = PC, 1 = rs.
- `alu_src_b` out 2: 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = use funct. Goes to ALU control.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 4: current state encoding, for debug.
- `illegal_op` out 1: sticky; set on an undecoded opcode.
- `mem_timeout` out 1: sticky; set when the wait counter reaches `MEM_WAIT_MAX`.

## Operation
- Opcodes:
  - R-type: 000000
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - j: 000010
  - addi: 001000
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- Every output not listed for a state is 0.
- FETCH:
  - Outputs: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write`=`pc_write`=`mem_ready` (Mealy on `mem_ready`).
  - Go to DECODE when `mem_ready`, else stay.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00.
  - Next state: lw/sw → MEM_ADDR; R-type → R_EXEC; beq → BRANCH; j → JUMP; addi → ADDI_EXEC.
  - Any other opcode: set `illegal_op` and go to FETCH.
- MEM_ADDR:
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `i_or_d`=1. Go to MEM_WB on `mem_ready`.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Go to FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. Go to FETCH on `mem_ready`.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Go to R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Go to FETCH.
- BRANCH:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - Go to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Go to FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Go to ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Go to FETCH.
- Wait counter:
  - 4-bit counter, cleared on entry to any memory state (FETCH, MEM_RD, MEM_WR).
  - Increments each cycle `mem_ready`=0 in those states.
  - Saturates at `MEM_WAIT_MAX`; on reaching it, sets `mem_timeout`.
  - The FSM keeps waiting; there is no abort.
- `illegal_op` and `mem_timeout` clear only on `reset`.

## Timing
- Reset values while `reset`=1:
  - `state`=FETCH, `mem_read`=1, `alu_src_b`=01, `illegal_op`=0, `mem_timeout`=0, counter=0.
  - `ir_write` and `pc_write` are forced 0 while `reset` is high.
  - All other outputs 0.
- Cycle counts with zero-wait memory (`mem_ready`=1 always):
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
- Each cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `opcode` is sampled only in DECODE and MEM_ADDR; it must be stable then (the IR holds it).
- `mem_ready` outside memory states is ignored.
- Reset asserted mid-instruction: state returns to FETCH immediately (asynchronously), with no partial writes after the edge.

## Test plan
- Reset, then lw with `mem_ready`=1 → states 0,1,2,3,4,0; `reg_write`=1 and `mem_to_reg`=1 only in cycle 5; `alu_op`=00 throughout.
- R-type (opcode 000000) → R_EXEC shows `alu_op`=10 and `alu_src_b`=00; R_WB shows `reg_dst`=1; 4 cycles total.
- beq → BRANCH shows `alu_op`=01, `pc_write_cond`=1 and `pc_source`=01 for exactly one cycle; j → `pc_write`=1 with `pc_source`=10.
- sw with `mem_ready` low for 3 cycles in MEM_WR → `mem_write` held 4 cycles; total 7 cycles; `mem_timeout`=0.
- `mem_ready` held low in FETCH for 15 cycles → `mem_timeout`=1 and stays 1 after `mem_ready` rises; the instruction then completes normally.
- Opcode 111111 → DECODE sets `illegal_op`=1 and returns to FETCH; `reset` asserted during R_EXEC → `state`=0 and `illegal_op`=0 before the next edge.
